// File: rtl/safebox_pkg.sv
// Shared types and constants for the safe-box keypad front end.
package safebox_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 5;
    localparam int unsigned KEY_W      = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_EMPTY = 5'd16;

    localparam logic [3:0] COL_0 = 4'b1110;
    localparam logic [3:0] COL_1 = 4'b1101;
    localparam logic [3:0] COL_2 = 4'b1011;
    localparam logic [3:0] COL_3 = 4'b0111;

    typedef enum logic {
        DEB_RELEASED,
        DEB_PRESSED
    } deb_state_t;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    col_drive = COL_0;
            2'd1:    col_drive = COL_1;
            2'd2:    col_drive = COL_2;
            default: col_drive = COL_3;
        endcase
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] row_index(input logic [3:0] low);
        row_index = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (low[i]) row_index = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row synchronizer, per-round single-key detection and debounce.
module keypad_scanner
    import safebox_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned DEB_SCANS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic             key_strobe,
    output logic [KEY_W-1:0] key_code
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_SCANS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       row_s1, row_s2;
    logic [1:0]       tag_d1, tag_d2;
    logic             acc_hit, acc_multi;
    logic [3:0]       acc_code;

    deb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       cand_code, cand_nx;
    logic             cand_vld, cand_vld_nx;
    logic             accept_c;
    logic             strobe_nx;
    logic [3:0]       code_nx;

    logic       slot_end_c, round_end_c;
    logic [3:0] low_c;
    logic       one_low_c, multi_c, round_valid_c;
    logic [3:0] sample_code_c, round_code_c;

    // The column tag travels with the row through the synchronizer so each sample
    // is attributed to the column that was actually driven when it was captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            col     <= COL_0;
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            tag_d1  <= 2'd0;
            tag_d2  <= 2'd0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            tag_d1 <= col_idx;
            tag_d2 <= tag_d1;
            if (slot_end_c) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= col_drive(col_idx + 2'd1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        slot_end_c    = (div_cnt == DIV_LAST);
        round_end_c   = slot_end_c && (tag_d2 == 2'd3);
        low_c         = ~row_s2;
        one_low_c     = (low_c != 4'd0) && ((low_c & (low_c - 4'd1)) == 4'd0);
        multi_c       = acc_multi || ((low_c != 4'd0) && !one_low_c) || (one_low_c && acc_hit);
        sample_code_c = {row_index(low_c), tag_d2};
        round_valid_c = (acc_hit || one_low_c) && !multi_c;
        round_code_c  = acc_hit ? acc_code : sample_code_c;
    end

    // Per-round accumulation of key sightings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (slot_end_c) begin
            if (round_end_c) begin
                acc_hit   <= 1'b0;
                acc_multi <= 1'b0;
            end else begin
                acc_multi <= multi_c;
                if (one_low_c && !acc_hit) begin
                    acc_hit  <= 1'b1;
                    acc_code <= sample_code_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DEB_RELEASED;
            cnt        <= '0;
            cand_code  <= 4'd0;
            cand_vld   <= 1'b0;
            key_strobe <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cand_code  <= cand_nx;
            cand_vld   <= cand_vld_nx;
            key_strobe <= strobe_nx;
            key_code   <= code_nx;
        end
    end

    // Debounce: count identical rounds while released, "none" rounds while pressed.
    always_comb begin
        logic [CNT_W-1:0] prior;
        state_nx    = state;
        cnt_nx      = cnt;
        cand_nx     = cand_code;
        cand_vld_nx = cand_vld;
        accept_c    = 1'b0;
        prior       = '0;
        if (round_end_c) begin
            case (state)
                DEB_RELEASED: begin
                    if (round_valid_c) begin
                        prior = (cand_vld && cand_code == round_code_c) ? cnt : '0;
                        if (prior == DEB_LAST) begin
                            accept_c    = 1'b1;
                            state_nx    = DEB_PRESSED;
                            cnt_nx      = '0;
                            cand_vld_nx = 1'b0;
                        end else begin
                            cnt_nx      = prior + CNT_W'(1);
                            cand_vld_nx = 1'b1;
                        end
                        cand_nx = round_code_c;
                    end else begin
                        cnt_nx      = '0;
                        cand_vld_nx = 1'b0;
                    end
                end
                default: begin
                    if (round_valid_c) begin
                        cnt_nx = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nx = DEB_RELEASED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        strobe_nx = accept_c;
        code_nx   = accept_c ? round_code_c : key_code;
    end

endmodule

// File: rtl/scan_password.sv
// Keypad password entry: scanner plus six-digit entry buffer with edge-triggered clears.
module scan_password
    import safebox_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SCAN_HZ   = 1_000,
    parameter int unsigned DEB_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst,
    input  logic       rst1,
    input  logic       rst2,
    input  logic       rst3,
    input  logic       rst4,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] p0,
    output logic [4:0] p1,
    output logic [4:0] p2,
    output logic [4:0] p3,
    output logic [4:0] p4,
    output logic [4:0] p5
);

    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic             key_strobe;
    logic [KEY_W-1:0] key_code;
    logic [4:0]       clr_in, clr_prev;
    logic             clr_edge_c;
    logic [2:0]       ptr;
    digit_t           p_q [NUM_DIGITS];

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    assign clr_in     = {rst, rst1, rst2, rst3, rst4};
    assign clr_edge_c = |(clr_in & ~clr_prev);

    // A clear edge takes priority over a coincident key; the debouncer stays latched,
    // so that key is only reported again after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_prev <= 5'd0;
            ptr      <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) p_q[i] <= DIGIT_EMPTY;
        end else begin
            clr_prev <= clr_in;
            if (clr_edge_c) begin
                ptr <= 3'd0;
                for (int i = 0; i < NUM_DIGITS; i++) p_q[i] <= DIGIT_EMPTY;
            end else if (key_strobe && ptr < 3'(NUM_DIGITS)) begin
                p_q[ptr] <= DIGIT_W'(key_code);
                ptr      <= ptr + 3'd1;
            end
        end
    end

    assign p0 = p_q[0];
    assign p1 = p_q[1];
    assign p2 = p_q[2];
    assign p3 = p_q[3];
    assign p4 = p_q[4];
    assign p5 = p_q[5];

endmodule

// File: tb/tb_scan_password.sv
// Directed bench for scan_password with a keypad model and an expected-buffer scoreboard.
module tb_scan_password;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst = 1'b0, rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0, rst4 = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] p0, p1, p2, p3, p4, p5;

    logic       ka_on = 1'b0, kb_on = 1'b0;
    logic [3:0] ka = 4'd0, kb = 4'd0;

    int total = 0;
    int bad = 0;
    int strobes = 0;

    logic [29:0] exp_q[$];
    logic [4:0]  m_buf [6];
    int          m_ptr;

    scan_password #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (500),
        .DEB_SCANS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rst   (rst),
        .rst1  (rst1),
        .rst2  (rst2),
        .rst3  (rst3),
        .rst4  (rst4),
        .row   (row),
        .col   (col),
        .p0    (p0),
        .p1    (p1),
        .p2    (p2),
        .p3    (p3),
        .p4    (p4),
        .p5    (p5)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        if (ka_on && col[ka[1:0]] == 1'b0) row[ka[3:2]] = 1'b0;
        if (kb_on && col[kb[1:0]] == 1'b0) row[kb[3:2]] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n && dut.u_scanner.key_strobe) strobes <= strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) m_buf[i] = 5'd16;
        m_ptr = 0;
    endtask

    task automatic model_key(input logic [3:0] code);
        if (m_ptr < 6) begin
            m_buf[m_ptr] = {1'b0, code};
            m_ptr++;
        end
    endtask

    task automatic push_exp();
        exp_q.push_back({m_buf[5], m_buf[4], m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
    endtask

    task automatic check_buf(input string tag);
        logic [29:0] e;
        e = exp_q.pop_front();
        check(tag, {2'b00, p5, p4, p3, p2, p1, p0}, {2'b00, e});
    endtask

    task automatic press_entry(input logic [3:0] code, input string tag);
        int s0;
        s0 = strobes;
        model_key(code);
        push_exp();
        ka = code;
        ka_on = 1'b1;
        repeat (40) @(negedge clk);
        ka_on = 1'b0;
        repeat (40) @(negedge clk);
        check({tag, "_strobe"}, 32'(strobes - s0), 32'd1);
        check_buf(tag);
    endtask

    task automatic pulse_clear(input int which);
        case (which)
            0: rst = 1'b1;
            2: rst2 = 1'b1;
            3: rst3 = 1'b1;
            default: rst4 = 1'b1;
        endcase
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0;
        int n;
        logic [3:0] ec;
        logic [3:0] extra [7];
        extra = '{4'd15, 4'd9, 4'd3, 4'd12, 4'd5, 4'd10, 4'd14};

        // reset state
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'(4'b1110));
        push_exp();
        check_buf("rst_p");

        // column rotation after release
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ec = 4'b0001 << ((k / 2) % 4);
            ec = ~ec;
            check("col_rot", 32'(col), 32'(ec));
            @(negedge clk);
        end
        repeat (34) @(negedge clk);
        push_exp();
        check_buf("idle_p");

        // single key (row1, col2)
        press_entry(4'd6, "key6");

        // four zeros then overflow
        pulse_clear(0);
        model_clear();
        push_exp();
        check_buf("clr_rst");
        for (int i = 0; i < 4; i++) press_entry(4'd0, "key0");
        for (int i = 0; i < 7; i++) press_entry(extra[i], "extra");

        // clears: rst2 pulse, then entry under held rst1
        pulse_clear(3);
        model_clear();
        press_entry(4'd1, "d1");
        press_entry(4'd2, "d2");
        press_entry(4'd3, "d3");
        pulse_clear(2);
        model_clear();
        push_exp();
        check_buf("clr_rst2");
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        model_clear();
        press_entry(4'd5, "held_rst1");
        rst1 = 1'b0;
        repeat (2) @(negedge clk);

        // strobe and rst4 edge in the same clock
        s0 = strobes;
        ka = 4'd9;
        ka_on = 1'b1;
        n = 0;
        while (!dut.u_scanner.key_strobe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 32'(n < 200), 32'd1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        model_clear();
        repeat (30) @(negedge clk);
        ka_on = 1'b0;
        repeat (40) @(negedge clk);
        push_exp();
        check_buf("clr_wins");
        check("clr_wins_strobe", 32'(strobes - s0), 32'd1);
        press_entry(4'd9, "after_clr");

        // two keys at once
        s0 = strobes;
        ka = 4'd1; kb = 4'd8;
        ka_on = 1'b1; kb_on = 1'b1;
        repeat (40) @(negedge clk);
        ka_on = 1'b0; kb_on = 1'b0;
        repeat (40) @(negedge clk);
        check("two_keys_strobe", 32'(strobes - s0), 32'd0);
        push_exp();
        check_buf("two_keys");

        // one-round bounce pulses
        s0 = strobes;
        ka = 4'd2;
        for (int i = 0; i < 5; i++) begin
            ka_on = 1'b1;
            repeat (8) @(negedge clk);
            ka_on = 1'b0;
            repeat (8) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("bounce_strobe", 32'(strobes - s0), 32'd0);
        push_exp();
        check_buf("bounce");

        // asynchronous reset mid-press
        press_entry(4'd3, "pre_rst");
        ka = 4'd10;
        ka_on = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstn_col", 32'(col), 32'(4'b1110));
        model_clear();
        push_exp();
        check_buf("rstn_p");
        ka_on = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        press_entry(4'd4, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
